// File: rtl/alu_seq_ctrl_if.sv
// Bus bundle between the command/result side and the ALU sequencer.
// slave = the sequencer itself, master = the environment that drives it.
interface alu_seq_ctrl_if #(parameter int CNT_W = 8);
  logic             ld_en;
  logic [1:0]       ld_addr;
  logic [7:0]       ld_data;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [1:0]       cmd_srca;
  logic [1:0]       cmd_srcb;
  logic             cmd_use_imm;
  logic [7:0]       cmd_imm;
  logic [1:0]       cmd_dst;

  logic             alu_f2, alu_f1, alu_f0;
  logic [7:0]       alu_a, alu_b;
  logic [7:0]       alu_r;
  logic             alu_ovf;

  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic             res_ovf;
  logic [1:0]       res_dst;

  logic             ovf_sticky;
  logic             clr_sticky;
  logic [CNT_W-1:0] op_cnt;

  modport slave (
    input  ld_en, ld_addr, ld_data,
    input  cmd_valid, cmd_op, cmd_srca, cmd_srcb, cmd_use_imm, cmd_imm, cmd_dst,
    output cmd_ready,
    output alu_f2, alu_f1, alu_f0, alu_a, alu_b,
    input  alu_r, alu_ovf,
    output res_valid, res_data, res_ovf, res_dst,
    input  res_ready,
    output ovf_sticky, op_cnt,
    input  clr_sticky
  );

  modport master (
    output ld_en, ld_addr, ld_data,
    output cmd_valid, cmd_op, cmd_srca, cmd_srcb, cmd_use_imm, cmd_imm, cmd_dst,
    input  cmd_ready,
    input  alu_f2, alu_f1, alu_f0, alu_a, alu_b,
    output alu_r, alu_ovf,
    input  res_valid, res_data, res_ovf, res_dst,
    output res_ready,
    input  ovf_sticky, op_cnt,
    output clr_sticky
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Command sequencer in front of a combinational 8-bit ALU: operand regfile,
// issue/capture/write-back FSM, result handshake, sticky overflow, op counter.
module alu_seq_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESULT} state_t;

  state_t           state;
  logic [3:0][7:0]  rf;

  logic [2:0]       op_q;
  logic [1:0]       srca_q, srcb_q, dst_q;
  logic             use_imm_q;
  logic [7:0]       imm_q;

  logic [2:0]       alu_f_q;
  logic [7:0]       alu_a_q, alu_b_q;
  logic             cmd_ready_q;
  logic             res_valid_q;
  logic [7:0]       res_data_q;
  logic             res_ovf_q;
  logic [1:0]       res_dst_q;
  logic             sticky_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rf          <= '0;
      op_q        <= '0;
      srca_q      <= '0;
      srcb_q      <= '0;
      dst_q       <= '0;
      use_imm_q   <= 1'b0;
      imm_q       <= '0;
      alu_f_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      cmd_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
      res_dst_q   <= '0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // A capture in the same cycle overrides this clear below.
      if (bus.clr_sticky) sticky_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.ld_en) rf[bus.ld_addr] <= bus.ld_data;
          if (bus.cmd_valid) begin
            op_q        <= bus.cmd_op;
            srca_q      <= bus.cmd_srca;
            srcb_q      <= bus.cmd_srcb;
            use_imm_q   <= bus.cmd_use_imm;
            imm_q       <= bus.cmd_imm;
            dst_q       <= bus.cmd_dst;
            cmd_ready_q <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          // Regfile read happens here, after any same-cycle load has landed.
          alu_f_q <= op_q;
          alu_a_q <= rf[srca_q];
          alu_b_q <= use_imm_q ? imm_q : rf[srcb_q];
          state   <= CAPTURE;
        end
        CAPTURE: begin
          res_data_q  <= bus.alu_r;
          res_ovf_q   <= bus.alu_ovf;
          res_dst_q   <= dst_q;
          rf[dst_q]   <= bus.alu_r;
          if (bus.alu_ovf) sticky_q <= 1'b1;
          res_valid_q <= 1'b1;
          state       <= RESULT;
        end
        RESULT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            cnt_q       <= cnt_q + 1'b1;
            cmd_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.alu_f2     = alu_f_q[2];
  assign bus.alu_f1     = alu_f_q[1];
  assign bus.alu_f0     = alu_f_q[0];
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_ovf    = res_ovf_q;
  assign bus.res_dst    = res_dst_q;
  assign bus.ovf_sticky = sticky_q;
  assign bus.op_cnt     = cnt_q;

endmodule
